// File: rtl/pmips_pkg.sv
// Shared definitions for the pmips 16-bit pipelined core: opcode/funct
// encodings, ALU operation enum, the nop word and the pipeline stage
// register layouts.
package pmips_pkg;

  localparam int unsigned XLEN     = 16;
  localparam int unsigned REG_BITS = 3;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_BEQ   = 3'd1;
  localparam logic [2:0] OP_BNE   = 3'd2;
  localparam logic [2:0] OP_J     = 3'd3;
  localparam logic [2:0] OP_LW    = 3'd4;
  localparam logic [2:0] OP_SW    = 3'd5;
  localparam logic [2:0] OP_SLTI  = 3'd6;
  localparam logic [2:0] OP_ADDI  = 3'd7;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_SLT = 4'd4;

  localparam logic [XLEN-1:0] NOP = 16'h0000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_NONE
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcp2;
  } ifid_t;

  // An all-zero ID/EX word has no side effects and acts as a bubble.
  typedef struct packed {
    alu_op_e             alu_op;
    logic                alu_imm;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                is_beq;
    logic                is_bne;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic [REG_BITS-1:0] dest;
    logic [XLEN-1:0]     rs_val;
    logic [XLEN-1:0]     rt_val;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     pcp2;
  } idex_t;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic [REG_BITS-1:0] dest;
    logic [XLEN-1:0]     result;
    logic [XLEN-1:0]     store;
  } exmem_t;

  typedef struct packed {
    logic                reg_write;
    logic [REG_BITS-1:0] dest;
    logic [XLEN-1:0]     value;
  } memwb_t;

  function automatic logic [XLEN-1:0] sext7(input logic [6:0] imm);
    return {{(XLEN-7){imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/pmips_if.sv
// Memory bus bundle between the pmips core and its instruction ROM / data
// memory. master = core side, slave = memory side.
//   imemaddr/imemrdata : fetch address and combinational instruction
//   dmemaddr/dmemwdata : MEM-stage address and store data
//   dmemwrite/dmemread : MEM-stage store / load enables
//   dmemrdata          : combinational load data
interface pmips_if;
  logic [15:0] imemaddr;
  logic [15:0] imemrdata;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;

  modport master (
    output imemaddr, dmemaddr, dmemwdata, dmemwrite, dmemread,
    input  imemrdata, dmemrdata
  );

  modport slave (
    input  imemaddr, dmemaddr, dmemwdata, dmemwrite, dmemread,
    output imemrdata, dmemrdata
  );
endinterface

// File: rtl/pmips_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write
// port, asynchronous clear. $0 reads as zero. A write in progress is
// bypassed to the read ports in the same cycle.
//   clock, reset       : clock, async active-high clear
//   raddr_a/rdata_a    : read port A
//   raddr_b/rdata_b    : read port B
//   we, waddr, wdata   : write port
//   debug              : contents of register DEBUG_REG
module pmips_regfile #(
  parameter logic [2:0] DEBUG_REG = 3'd7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  raddr_a,
  output logic [15:0] rdata_a,
  input  logic [2:0]  raddr_b,
  output logic [15:0] rdata_b,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  output logic [15:0] debug
);

  logic [15:0] regs [8];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 :
                   (we && waddr == raddr_a) ? wdata : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 :
                   (we && waddr == raddr_b) ? wdata : regs[raddr_b];
  assign debug   = regs[DEBUG_REG];

endmodule

// File: rtl/pmips_core.sv
// 16-bit 5-stage (IF/ID/EX/MEM/WB) MIPS-like core with 8 registers.
//   imemaddr/imemrdata : IF-stage PC and combinational instruction
//   dmemaddr/dmemwdata/dmemwrite/dmemread/dmemrdata : MEM-stage data port
//   aluresult          : combinational EX-stage ALU output
//   debug              : register DEBUG_REG
//   stall              : load-use bubble being inserted
//   clock, reset       : rising-edge clock, async active-high reset
module pmips_core
  import pmips_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [2:0]  DEBUG_REG = 3'd7
) (
  output logic [15:0] imemaddr,
  output logic [15:0] dmemaddr,
  output logic [15:0] dmemwdata,
  output logic        dmemwrite,
  output logic        dmemread,
  output logic [15:0] aluresult,
  input  logic        clock,
  input  logic [15:0] imemrdata,
  input  logic [15:0] dmemrdata,
  input  logic        reset,
  output logic [15:0] debug,
  output logic        stall
);

  logic [15:0] pc, pc_next, pc_plus2;
  ifid_t       ifid, ifid_next;
  idex_t       idex, idex_next, id_dec;
  exmem_t      exmem, exmem_next;
  memwb_t      memwb, memwb_next;

  logic [15:0] rf_a, rf_b;
  logic        reads_rs, reads_rt, id_jump, load_use;
  logic [15:0] jump_target;
  logic [15:0] fwd_a, fwd_b, alu_b, alu_y, br_target;
  logic        br_taken;

  assign pc_plus2 = pc + 16'd2;
  assign imemaddr = {pc[15:1], 1'b0};

  pmips_regfile #(.DEBUG_REG(DEBUG_REG)) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .raddr_a (ifid.instr[12:10]),
    .rdata_a (rf_a),
    .raddr_b (ifid.instr[9:7]),
    .rdata_b (rf_b),
    .we      (memwb.reg_write),
    .waddr   (memwb.dest),
    .wdata   (memwb.value),
    .debug   (debug)
  );

  // ID: decode, register read, jump resolution
  always_comb begin
    id_dec        = '0;
    id_dec.rs     = ifid.instr[12:10];
    id_dec.rt     = ifid.instr[9:7];
    id_dec.rs_val = rf_a;
    id_dec.rt_val = rf_b;
    id_dec.imm    = sext7(ifid.instr[6:0]);
    id_dec.pcp2   = ifid.pcp2;
    reads_rs      = 1'b1;
    reads_rt      = 1'b0;
    id_jump       = 1'b0;
    case (ifid.instr[15:13])
      OP_RTYPE: begin
        reads_rt         = 1'b1;
        id_dec.dest      = ifid.instr[6:4];
        id_dec.reg_write = 1'b1;
        case (ifid.instr[3:0])
          FN_ADD:  id_dec.alu_op = ALU_ADD;
          FN_SUB:  id_dec.alu_op = ALU_SUB;
          FN_AND:  id_dec.alu_op = ALU_AND;
          FN_OR:   id_dec.alu_op = ALU_OR;
          FN_SLT:  id_dec.alu_op = ALU_SLT;
          default: begin
            id_dec.alu_op    = ALU_NONE;
            id_dec.reg_write = 1'b0;
          end
        endcase
      end
      OP_BEQ, OP_BNE: begin
        reads_rt      = 1'b1;
        id_dec.alu_op = ALU_SUB;
        id_dec.is_beq = (ifid.instr[15:13] == OP_BEQ);
        id_dec.is_bne = (ifid.instr[15:13] == OP_BNE);
      end
      OP_J: begin
        reads_rs = 1'b0;
        id_jump  = 1'b1;
      end
      OP_LW: begin
        id_dec.alu_imm   = 1'b1;
        id_dec.mem_read  = 1'b1;
        id_dec.reg_write = 1'b1;
        id_dec.dest      = ifid.instr[9:7];
      end
      OP_SW: begin
        reads_rt         = 1'b1;
        id_dec.alu_imm   = 1'b1;
        id_dec.mem_write = 1'b1;
      end
      OP_SLTI: begin
        id_dec.alu_op    = ALU_SLT;
        id_dec.alu_imm   = 1'b1;
        id_dec.reg_write = 1'b1;
        id_dec.dest      = ifid.instr[9:7];
      end
      default: begin // OP_ADDI
        id_dec.alu_imm   = 1'b1;
        id_dec.reg_write = 1'b1;
        id_dec.dest      = ifid.instr[9:7];
      end
    endcase
  end

  assign jump_target = {ifid.pcp2[15:14], ifid.instr[12:0], 1'b0};

  assign load_use = idex.mem_read && (idex.dest != '0) &&
                    ((reads_rs && id_dec.rs == idex.dest) ||
                     (reads_rt && id_dec.rt == idex.dest));

  // EX: operand forwarding, EX/MEM before MEM/WB. An EX/MEM load never
  // matches here because the load-use bubble separates them.
  always_comb begin
    fwd_a = idex.rs_val;
    if (exmem.reg_write && exmem.dest != '0 && exmem.dest == idex.rs)
      fwd_a = exmem.result;
    else if (memwb.reg_write && memwb.dest != '0 && memwb.dest == idex.rs)
      fwd_a = memwb.value;
    fwd_b = idex.rt_val;
    if (exmem.reg_write && exmem.dest != '0 && exmem.dest == idex.rt)
      fwd_b = exmem.result;
    else if (memwb.reg_write && memwb.dest != '0 && memwb.dest == idex.rt)
      fwd_b = memwb.value;
  end

  assign alu_b = idex.alu_imm ? idex.imm : fwd_b;

  always_comb begin
    alu_y = '0;
    case (idex.alu_op)
      ALU_ADD: alu_y = fwd_a + alu_b;
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_OR:  alu_y = fwd_a | alu_b;
      ALU_SLT: alu_y = {15'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

  assign aluresult = alu_y;
  assign br_taken  = (idex.is_beq && fwd_a == fwd_b) ||
                     (idex.is_bne && fwd_a != fwd_b);
  assign br_target = idex.pcp2 + {idex.imm[14:0], 1'b0};
  // A branch in EX and a load in EX are mutually exclusive, but the
  // branch is given priority explicitly.
  assign stall     = load_use && !br_taken;

  always_comb begin
    exmem_next.reg_write = idex.reg_write;
    exmem_next.mem_read  = idex.mem_read;
    exmem_next.mem_write = idex.mem_write;
    exmem_next.dest      = idex.dest;
    exmem_next.result    = alu_y;
    exmem_next.store     = fwd_b;
  end

  // MEM
  assign dmemaddr  = exmem.result;
  assign dmemwdata = exmem.store;
  assign dmemwrite = exmem.mem_write;
  assign dmemread  = exmem.mem_read;

  always_comb begin
    memwb_next.reg_write = exmem.reg_write;
    memwb_next.dest      = exmem.dest;
    memwb_next.value     = exmem.mem_read ? dmemrdata : exmem.result;
  end

  // Front-end steering: taken branch, then load-use hold, then jump.
  always_comb begin
    pc_next         = pc_plus2;
    ifid_next.instr = imemrdata;
    ifid_next.pcp2  = pc_plus2;
    idex_next       = id_dec;
    if (br_taken) begin
      pc_next   = br_target;
      ifid_next = '0;
      idex_next = '0;
    end else if (load_use) begin
      pc_next   = pc;
      ifid_next = ifid;
      idex_next = '0;
    end else if (id_jump) begin
      pc_next   = jump_target;
      ifid_next = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      ifid  <= '0;
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      pc    <= pc_next;
      ifid  <= ifid_next;
      idex  <= idex_next;
      exmem <= exmem_next;
      memwb <= memwb_next;
    end
  end

endmodule

// File: tb/tb_pmips_core.sv
// Directed bench for pmips_core: a table of short programs checked through
// the debug register, plus cycle-accurate sequences for load-use stall,
// branch/jump redirect, reset values and asynchronous mid-program reset.
module tb_pmips_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_clear;
  logic [15:0] debug;
  logic [15:0] aluresult;
  logic        stall;

  pmips_if bus();

  logic [15:0] imem [64];
  logic [15:0] dmem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bus.imemrdata = imem[bus.imemaddr[6:1]];
  assign bus.dmemrdata = dmem[bus.dmemaddr[6:1]];

  always @(posedge clk) begin
    if (dmem_clear) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 16'h0000;
    end else if (bus.dmemwrite) begin
      dmem[bus.dmemaddr[6:1]] <= bus.dmemwdata;
    end
  end

  pmips_core #(.RESET_PC(16'h0000), .DEBUG_REG(3'd7)) dut (
    .imemaddr  (bus.imemaddr),
    .dmemaddr  (bus.dmemaddr),
    .dmemwdata (bus.dmemwdata),
    .dmemwrite (bus.dmemwrite),
    .dmemread  (bus.dmemread),
    .aluresult (aluresult),
    .clock     (clk),
    .imemrdata (bus.imemrdata),
    .dmemrdata (bus.dmemrdata),
    .reset     (rst),
    .debug     (debug),
    .stall     (stall)
  );

  // ---- instruction encoders ----
  function automatic logic [15:0] enc_r(input int fn, input int rd, input int rs, input int rt);
    logic [31:0] f, d, s, t;
    f = fn; d = rd; s = rs; t = rt;
    return {3'b000, s[2:0], t[2:0], d[2:0], f[3:0]};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rt, input int rs, input int imm);
    logic [31:0] o, t, s, m;
    o = op; t = rt; s = rs; m = imm;
    return {o[2:0], s[2:0], t[2:0], m[6:0]};
  endfunction

  function automatic logic [15:0] i_add(input int d, input int s, input int t); return enc_r(0, d, s, t); endfunction
  function automatic logic [15:0] i_sub(input int d, input int s, input int t); return enc_r(1, d, s, t); endfunction
  function automatic logic [15:0] i_and(input int d, input int s, input int t); return enc_r(2, d, s, t); endfunction
  function automatic logic [15:0] i_or (input int d, input int s, input int t); return enc_r(3, d, s, t); endfunction
  function automatic logic [15:0] i_slt(input int d, input int s, input int t); return enc_r(4, d, s, t); endfunction
  function automatic logic [15:0] i_beq(input int s, input int t, input int off); return enc_i(1, t, s, off); endfunction
  function automatic logic [15:0] i_bne(input int s, input int t, input int off); return enc_i(2, t, s, off); endfunction
  function automatic logic [15:0] i_lw  (input int t, input int off, input int s); return enc_i(4, t, s, off); endfunction
  function automatic logic [15:0] i_sw  (input int t, input int off, input int s); return enc_i(5, t, s, off); endfunction
  function automatic logic [15:0] i_slti(input int t, input int s, input int imm); return enc_i(6, t, s, imm); endfunction
  function automatic logic [15:0] i_addi(input int t, input int s, input int imm); return enc_i(7, t, s, imm); endfunction
  function automatic logic [15:0] i_j(input int a);
    logic [31:0] v;
    v = a;
    return {3'b011, v[12:0]};
  endfunction

  // ---- vector table ----
  typedef struct {
    string            name;
    logic [7:0][15:0] prog;
    logic [15:0]      exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input int exp,
                              input logic [15:0] w0, input logic [15:0] w1 = 16'h0000,
                              input logic [15:0] w2 = 16'h0000, input logic [15:0] w3 = 16'h0000,
                              input logic [15:0] w4 = 16'h0000, input logic [15:0] w5 = 16'h0000,
                              input logic [15:0] w6 = 16'h0000, input logic [15:0] w7 = 16'h0000);
    vec_t        r;
    logic [31:0] e;
    e = exp;
    r.name = nm;
    r.exp  = e[15:0];
    r.prog[0] = w0; r.prog[1] = w1; r.prog[2] = w2; r.prog[3] = w3;
    r.prog[4] = w4; r.prog[5] = w5; r.prog[6] = w6; r.prog[7] = w7;
    return r;
  endfunction

  // ---- helpers ----
  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dmem_clear = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dmem_clear = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dmem_clear = 1'b1;
    clear_imem();

    // ---- reset values ----
    @(posedge clk); #1;
    check16("rst_imemaddr",  bus.imemaddr,  16'h0000);
    check1 ("rst_dmemwrite", bus.dmemwrite, 1'b0);
    check1 ("rst_dmemread",  bus.dmemread,  1'b0);
    check1 ("rst_stall",     stall,         1'b0);
    check16("rst_dmemaddr",  bus.dmemaddr,  16'h0000);
    check16("rst_dmemwdata", bus.dmemwdata, 16'h0000);
    check16("rst_debug",     debug,         16'h0000);

    // ---- table of programs, result read through $7 ----
    vecs.push_back(mk("add_fwd",    8,  i_addi(1,0,5),  i_addi(2,0,3),  i_add(3,1,2), i_add(7,3,0)));
    vecs.push_back(mk("sub_neg",    1,  i_addi(1,0,-1), i_sub(2,0,1),   i_add(7,2,0)));
    vecs.push_back(mk("slt_true",   1,  i_addi(1,0,-1), i_addi(2,0,1),  i_slt(7,1,2)));
    vecs.push_back(mk("slt_false",  0,  i_addi(7,0,3),  i_addi(1,0,-1), i_addi(2,0,1), i_slt(7,2,1)));
    vecs.push_back(mk("and",        20, i_addi(1,0,53), i_addi(2,0,28), i_and(7,1,2)));
    vecs.push_back(mk("or",         61, i_addi(1,0,53), i_addi(2,0,28), i_or(7,1,2)));
    vecs.push_back(mk("slti_true",  1,  i_addi(1,0,-5), i_slti(7,1,-4)));
    vecs.push_back(mk("slti_eq",    0,  i_addi(7,0,3),  i_addi(1,0,-5), i_slti(7,1,-5)));
    vecs.push_back(mk("zero_reg",   3,  i_addi(7,0,3),  i_addi(0,0,5),  i_add(7,7,0)));
    vecs.push_back(mk("wb_bypass",  14, i_addi(1,0,7),  16'h0000,       16'h0000,     i_add(7,1,1)));
    vecs.push_back(mk("load_use",   10, i_addi(1,0,5),  i_sw(1,4,0),    i_lw(4,4,0),  i_add(7,4,4)));
    vecs.push_back(mk("beq_flush",  4,  i_beq(0,0,2),   i_addi(7,0,1),  i_addi(7,7,2), i_addi(7,7,4)));
    vecs.push_back(mk("bne_taken",  6,  i_addi(1,0,1),  i_bne(1,0,1),   i_addi(7,0,9), i_addi(7,7,6)));
    vecs.push_back(mk("bne_loop",   2,  i_addi(1,0,2),  i_addi(7,7,1),  i_addi(1,1,-1), i_bne(1,0,-3)));
    vecs.push_back(mk("lw_sw_lw",   6,  i_addi(1,0,6),  i_sw(1,8,0),    i_lw(2,8,0),  i_sw(2,10,0), i_lw(7,10,0)));

    foreach (vecs[k]) begin
      clear_imem();
      for (int w = 0; w < 8; w++) imem[w] = vecs[k].prog[w];
      do_reset();
      step(24);
      check16(vecs[k].name, debug, vecs[k].exp);
    end

    // ---- first fetch, EX result and no stall on pure ALU code ----
    begin
      int nstall;
      clear_imem();
      imem[0] = i_addi(1,0,5); imem[1] = i_addi(2,0,3);
      imem[2] = i_add(3,1,2);  imem[3] = i_add(7,3,0);
      do_reset();
      check16("fetch_pre_edge", bus.imemaddr, 16'h0000);
      nstall = 0;
      for (int c = 1; c <= 10; c++) begin
        step(1);
        if (stall) nstall++;
        if (c == 1) check16("fetch_edge1", bus.imemaddr, 16'h0002);
        if (c == 3) check16("alu_addi2", aluresult, 16'h0003);
        if (c == 4) check16("alu_add8", aluresult, 16'h0008);
      end
      check16("alu_no_stall", nstall[15:0], 16'h0000);
      check16("alu_debug", debug, 16'h0008);
    end

    // ---- load-use trace: store, load, dependent add ----
    clear_imem();
    imem[0] = i_addi(1,0,5); imem[1] = i_sw(1,4,0); imem[2] = i_lw(4,4,0);
    imem[3] = i_add(5,4,4);  imem[4] = i_add(7,5,0);
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      step(1);
      check1($sformatf("lu_stall_c%0d", c), stall, (c == 4));
      if (c == 4) begin
        check16("lu_pc_c4", bus.imemaddr, 16'h0008);
        check1 ("lu_sw_we", bus.dmemwrite, 1'b1);
        check16("lu_sw_addr", bus.dmemaddr, 16'h0004);
        check16("lu_sw_data", bus.dmemwdata, 16'h0005);
      end
      if (c == 5) begin
        check16("lu_pc_hold", bus.imemaddr, 16'h0008);
        check1 ("lu_lw_re", bus.dmemread, 1'b1);
        check1 ("lu_lw_nowe", bus.dmemwrite, 1'b0);
        check16("lu_lw_addr", bus.dmemaddr, 16'h0004);
      end
      if (c == 6) check16("lu_pc_resume", bus.imemaddr, 16'h000a);
    end
    step(10);
    check16("lu_mem_word", dmem[2], 16'h0005);
    check16("lu_debug", debug, 16'h000a);

    // ---- taken branch redirect: beq $0,$0,+5 from PC 0 -> 12 ----
    clear_imem();
    imem[0] = i_beq(0,0,5); imem[1] = i_addi(7,0,1); imem[2] = i_addi(7,7,2);
    imem[6] = i_addi(7,7,4);
    do_reset();
    step(2);
    check16("br_pc_e2", bus.imemaddr, 16'h0004);
    step(1);
    check16("br_pc_target", bus.imemaddr, 16'h000c);
    step(1);
    check16("br_pc_after", bus.imemaddr, 16'h000e);
    step(12);
    check16("br_debug", debug, 16'h0004);

    // ---- jump to 0x0010 -> fetch address 0x0020, one bubble ----
    clear_imem();
    imem[0] = i_j(16'h0010); imem[1] = i_addi(7,0,1); imem[16] = i_addi(7,7,9);
    do_reset();
    step(1);
    check16("j_pc_e1", bus.imemaddr, 16'h0002);
    step(1);
    check16("j_pc_target", bus.imemaddr, 16'h0020);
    step(12);
    check16("j_debug", debug, 16'h0009);

    // ---- asynchronous reset with a store in MEM ----
    clear_imem();
    imem[0] = i_addi(7,0,9); imem[1] = i_addi(2,0,11); imem[2] = i_sw(2,8,0);
    do_reset();
    step(5);
    check16("mr_debug_pre", debug, 16'h0009);
    check1 ("mr_we_pre", bus.dmemwrite, 1'b1);
    check16("mr_addr_pre", bus.dmemaddr, 16'h0008);
    rst = 1'b1;
    #1;
    check16("mr_imemaddr", bus.imemaddr, 16'h0000);
    check1 ("mr_dmemwrite", bus.dmemwrite, 1'b0);
    check16("mr_debug", debug, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check16("mr_no_store", dmem[4], 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
